// File: rtl/addsub_accumulator.sv
// ============================================================================
// Module   : addsub_accumulator
// Brief    : Streaming signed add/sub accumulator with per-step overflow
//            detection, sticky overflow flag and a registered valid/ready
//            result port. Define ADDSUB_ACC_SATURATE_EN to clamp on overflow.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module addsub_accumulator #(
    parameter int WIDTH     = 8,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_data,
    input  logic                 in_op,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_sum,
    output logic                 out_overflow,
    output logic [CNT_WIDTH-1:0] out_count
);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_accum = 2'd1;
    localparam logic [1:0] c_st_done  = 2'd2;

    localparam logic [WIDTH-1:0]     c_max_pos = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0]     c_max_neg = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [CNT_WIDTH-1:0] c_cnt_max = {CNT_WIDTH{1'b1}};

    logic [1:0]           r_state;
    logic [1:0]           w_state_nxt;

    logic [WIDTH-1:0]     r_acc;
    logic                 r_sticky;
    logic [CNT_WIDTH-1:0] r_count;

    logic [WIDTH-1:0]     r_out_sum;
    logic                 r_out_overflow;
    logic [CNT_WIDTH-1:0] r_out_count;

    logic                 w_accept;
    logic                 w_handshake;
    logic                 w_in_idle;

    logic [WIDTH-1:0]     w_base;
    logic [WIDTH-1:0]     w_operand;
    logic [WIDTH-1:0]     w_raw;
    logic [WIDTH-1:0]     w_acc_nxt;
    logic                 w_sticky_base;
    logic                 w_sticky_nxt;
    logic [CNT_WIDTH-1:0] w_count_base;
    logic [CNT_WIDTH-1:0] w_count_nxt;
    logic                 w_sign_base;
    logic                 w_sign_data;
    logic                 w_sign_raw;
    logic                 w_step_ovf;

    // in_ready is gated by rst_n so it drops the instant reset asserts.
    assign in_ready    = rst_n && (r_state != c_st_done);
    assign out_valid   = (r_state == c_st_done);
    assign w_accept    = in_valid && in_ready;
    assign w_handshake = out_valid && out_ready;
    assign w_in_idle   = (r_state == c_st_idle);

    // A new frame starts from zero regardless of leftover register contents.
    assign w_base        = w_in_idle ? '0 : r_acc;
    assign w_sticky_base = w_in_idle ? 1'b0 : r_sticky;
    assign w_count_base  = w_in_idle ? '0 : r_count;

    assign w_operand = in_op ? ~in_data : in_data;
    assign w_raw     = w_base + w_operand + {{(WIDTH-1){1'b0}}, in_op};

    assign w_sign_base = w_base[WIDTH-1];
    assign w_sign_data = in_data[WIDTH-1];
    assign w_sign_raw  = w_raw[WIDTH-1];

    assign w_step_ovf = (in_op ? (w_sign_base != w_sign_data)
                               : (w_sign_base == w_sign_data))
                        && (w_sign_raw != w_sign_base);

`ifdef ADDSUB_ACC_SATURATE_EN
    // Overflow always flips the sign away from the base, so the true
    // result lies on the base's side of zero.
    assign w_acc_nxt = w_step_ovf ? (w_sign_base ? c_max_neg : c_max_pos)
                                  : w_raw;
`else
    assign w_acc_nxt = w_raw;
`endif

    assign w_sticky_nxt = w_sticky_base | w_step_ovf;
    assign w_count_nxt  = (w_count_base == c_cnt_max) ? c_cnt_max
                                                      : w_count_base + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: begin
                if (w_accept) begin
                    w_state_nxt = in_last ? c_st_done : c_st_accum;
                end
            end
            c_st_accum: begin
                if (w_accept && in_last) begin
                    w_state_nxt = c_st_done;
                end
            end
            c_st_done: begin
                if (w_handshake) begin
                    w_state_nxt = c_st_idle;
                end
            end
            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc          <= '0;
            r_sticky       <= 1'b0;
            r_count        <= '0;
            r_out_sum      <= '0;
            r_out_overflow <= 1'b0;
            r_out_count    <= '0;
        end else if (w_accept) begin
            r_acc    <= w_acc_nxt;
            r_sticky <= w_sticky_nxt;
            r_count  <= w_count_nxt;
            if (in_last) begin
                r_out_sum      <= w_acc_nxt;
                r_out_overflow <= w_sticky_nxt;
                r_out_count    <= w_count_nxt;
            end
        end else if (w_handshake) begin
            r_acc    <= '0;
            r_sticky <= 1'b0;
            r_count  <= '0;
        end
    end

    assign out_sum      = r_out_sum;
    assign out_overflow = r_out_overflow;
    assign out_count    = r_out_count;

endmodule

`default_nettype wire

// File: tb/tb_addsub_accumulator.sv
// ============================================================================
// Module   : tb_addsub_accumulator
// Brief    : Self-checking bench for addsub_accumulator; follows
//            ADDSUB_ACC_SATURATE_EN to select wrap or clamp expectations.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_addsub_accumulator;

`ifdef ADDSUB_ACC_SATURATE_EN
    localparam bit c_sat = 1'b1;
`else
    localparam bit c_sat = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       in_op;
    logic       in_last;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_sum;
    logic       out_overflow;
    logic [7:0] out_count;

    int n_assert;
    int n_fail;

    int q_d[$];
    bit q_op[$];

    addsub_accumulator #(
        .WIDTH     (8),
        .CNT_WIDTH (8)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_op        (in_op),
        .in_last      (in_last),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_sum      (out_sum),
        .out_overflow (out_overflow),
        .out_count    (out_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic add_beat(input int d, input bit op);
        q_d.push_back(d);
        q_op.push_back(op);
    endtask

    // Reference: exact integer sum per step, then wrap or clamp into 8 bits.
    task automatic model(output int sum8, output int ovf, output int cnt);
        int a;
        int t;
        a   = 0;
        ovf = 0;
        cnt = 0;
        for (int i = 0; i < q_d.size(); i++) begin
            t = q_op[i] ? a - q_d[i] : a + q_d[i];
            if (t > 127 || t < -128) begin
                ovf = 1;
                if (c_sat) a = (t > 127) ? 127 : -128;
                else       a = (t > 127) ? t - 256 : t + 256;
            end else begin
                a = t;
            end
            if (cnt < 255) cnt++;
        end
        sum8 = a & 255;
    endtask

    // Sends the queued frame, checks the result, holds backpressure for
    // 'hold' cycles while offering a stray beat, then completes the handshake.
    task automatic run_frame(input string tag, input int hold);
        int exp_sum;
        int exp_ovf;
        int exp_cnt;
        int v;
        model(exp_sum, exp_ovf, exp_cnt);
        for (int i = 0; i < q_d.size(); i++) begin
            @(negedge clk);
            if (i == 1) check({tag, ".busy_valid"}, {31'b0, out_valid}, 0);
            v        = q_d[i];
            in_valid = 1'b1;
            in_data  = v[7:0];
            in_op    = q_op[i];
            in_last  = (i == q_d.size() - 1);
        end
        @(negedge clk);
        in_valid = 1'b1;
        v        = int'($urandom_range(0, 255));
        in_data  = v[7:0];
        in_op    = 1'b0;
        in_last  = 1'b1;
        check({tag, ".valid"}, {31'b0, out_valid}, 1);
        check({tag, ".sum"}, {24'b0, out_sum}, exp_sum);
        check({tag, ".ovf"}, {31'b0, out_overflow}, exp_ovf);
        check({tag, ".count"}, {24'b0, out_count}, exp_cnt);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check({tag, ".hold_valid"}, {31'b0, out_valid}, 1);
            check({tag, ".hold_ready"}, {31'b0, in_ready}, 0);
            check({tag, ".hold_sum"}, {24'b0, out_sum}, exp_sum);
            check({tag, ".hold_count"}, {24'b0, out_count}, exp_cnt);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        check({tag, ".post_valid"}, {31'b0, out_valid}, 0);
        check({tag, ".post_ready"}, {31'b0, in_ready}, 1);
        check({tag, ".post_sum"}, {24'b0, out_sum}, exp_sum);
        q_d.delete();
        q_op.delete();
    endtask

    initial begin
        n_assert  = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_op     = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b0;

        #1;
        check("rst.in_ready", {31'b0, in_ready}, 0);
        check("rst.out_valid", {31'b0, out_valid}, 0);
        check("rst.out_sum", {24'b0, out_sum}, 0);
        check("rst.out_ovf", {31'b0, out_overflow}, 0);
        check("rst.out_count", {24'b0, out_count}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("idle.in_ready", {31'b0, in_ready}, 1);

        add_beat(13, 0);  add_beat(12, 0);   run_frame("f_add", 0);
        add_beat(13, 0);  add_beat(-12, 1);  run_frame("f_subneg", 0);
        add_beat(-13, 0); add_beat(12, 1);   run_frame("f_negsub", 1);
        add_beat(-13, 0); add_beat(-12, 1);  run_frame("f_m1", 0);
        add_beat(127, 0); add_beat(127, 0);  run_frame("f_posovf", 0);
        add_beat(-127, 0); add_beat(-127, 0); run_frame("f_negovf", 0);
        add_beat(127, 0); add_beat(1, 0); add_beat(1, 1); run_frame("f_sticky", 0);
        add_beat(-128, 1);                   run_frame("f_sub_min", 0);
        add_beat(-128, 0); add_beat(1, 1);   run_frame("f_min_m1", 0);
        add_beat(7, 0); add_beat(9, 1);      run_frame("f_bp", 5);

        for (int i = 0; i < 300; i++) add_beat(1, 0);
        run_frame("f_cntsat", 0);

        // Abort a frame part-way with an asynchronous reset pulse.
        add_beat(20, 0); run_frame("f_pre_abort", 0);
        @(negedge clk);
        in_valid = 1'b1; in_data = 8'd50; in_op = 1'b0; in_last = 1'b0;
        @(negedge clk);
        in_data = 8'd60;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort.in_ready", {31'b0, in_ready}, 0);
        check("abort.out_valid", {31'b0, out_valid}, 0);
        check("abort.out_sum", {24'b0, out_sum}, 0);
        check("abort.out_count", {24'b0, out_count}, 0);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        add_beat(1, 0); run_frame("f_after_abort", 0);

        for (int f = 0; f < 25; f++) begin
            int len;
            len = int'($urandom_range(1, 6));
            for (int b = 0; b < len; b++)
                add_beat(int'($urandom_range(0, 255)) - 128, 1'($urandom_range(0, 1)));
            run_frame($sformatf("rnd%0d", f), int'($urandom_range(0, 3)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/addsub_accumulator.md
Name: addsub_accumulator

Overview:
- Streaming signed accumulator that consumes a sequence of 8-bit two's-complement operands, each tagged add or subtract.
- Keeps a running sum with per-step overflow detection (same sign rules as the team's 8-bit adder/subtractor) and a sticky overflow flag.
- On the frame's last operand, presents the result on a registered valid/ready output port.
- Sits downstream of operand sources as the consumer/checker side of the add/sub datapath.

Parameters:
- WIDTH, 8, operand and accumulator width in bits (two's complement).
- CNT_WIDTH, 8, width of the per-frame operand counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block can accept an operand this cycle.
- in_data  input  WIDTH  signed operand.
- in_op  input  1  0 = acc + in_data; 1 = acc - in_data.
- in_last  input  1  beat is the final operand of the frame.
- out_valid  output  1  frame result valid.
- out_ready  input  1  downstream accepts result.
- out_sum  output  WIDTH  final accumulator value.
- out_overflow  output  1  sticky: any step in the frame overflowed.
- out_count  output  CNT_WIDTH  operands accepted in the frame, saturating at 2^CNT_WIDTH-1.

Behaviour:
- Reset (async, rst_n low): state=IDLE; acc=0, sticky=0, count=0; in_ready=0 while rst_n low, otherwise 1 in IDLE; out_valid=0, out_sum=0, out_overflow=0, out_count=0.
- States: IDLE, ACCUM, DONE.
- Accept rule: a beat is accepted when in_valid && in_ready. in_ready=1 in IDLE and ACCUM, 0 in DONE.
- Accumulation (per accepted beat):
  - Base is 0 in IDLE, acc in ACCUM.
  - r = base + in_data (op=0) or base + ~in_data + 1 (op=1), truncated to WIDTH.
  - Step overflow, add: sign(base)==sign(in_data) and sign(r)!=sign(base).
  - Step overflow, subtract: sign(base)!=sign(in_data) and sign(r)!=sign(base).
  - sticky |= step overflow. count increments, saturating at max.
- Transitions:
  - IDLE, accepted beat with in_last=0 -> ACCUM.
  - IDLE or ACCUM, accepted beat with in_last=1 -> DONE. Single-beat frames are legal.
  - ACCUM, no accepted beat -> stays in ACCUM, registers hold.
- DONE:
  - out_valid=1, asserted the cycle after the last beat is accepted (latency 1).
  - out_sum, out_overflow and out_count are registered and held stable while out_ready=0.
  - On out_valid && out_ready: clear acc, sticky and count; go to IDLE; out_valid=0 next cycle; in_ready=1 next cycle. No same-cycle accept of a new frame.
- Boundaries:
  - 0 - (-128) overflows, wraps to -128.
  - -128 - 1 overflows, wraps to 127.
  - Sticky flag never clears mid-frame even if the sum returns in range.
  - in_valid in DONE is ignored; the source must hold the beat.
  - rst_n asserted mid-frame or in DONE aborts the frame with no output.
- out_* registers change only on the DONE entry edge and on reset.

Optional Feature:
- Macro: ADDSUB_ACC_SATURATE_EN.
- Defined: on step overflow, acc clamps to the signed extreme in the direction of the true result. Positive overflow gives 2^(WIDTH-1)-1 (127); negative overflow gives -2^(WIDTH-1) (-128). The sticky flag is still set, and subsequent steps use the clamped value.
- Undefined: acc wraps modulo 2^WIDTH.
- Handshake and latency are identical in both builds.

Test Plan:
- Frame {+13, +12 last} -> out_sum=25, out_overflow=0, out_count=2, out_valid one cycle after the last beat.
- Frames {+13, -(-12) last} -> 25 ovf=0; {-13, -(12) last} -> -25 (0xE7) ovf=0; {-13, -(-12) last} -> -1 ovf=0.
- Frame {+127, +127 last} -> wrap build: 0xFE (-2) ovf=1; SATURATE_EN build: 127 ovf=1. Frame {-127, +(-127) last} -> wrap: 2 ovf=1; saturate: -128 ovf=1.
- Sticky check: frame {+127, +1, -(1) last} -> wrap: 127 ovf=1; saturate: 126 ovf=1. Single beat {-(-128) last} -> -128 ovf=1 (wrap) / 127 ovf=1 (saturate).
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> outputs stable, in_ready=0, offered beats not consumed. Raise out_ready -> next frame starts with acc=0, count=0.
- Reset mid-frame: after beats {+50, +60}, pulse rst_n low asynchronously -> all outputs 0 immediately. Next frame {+1 last} -> out_sum=1, count=1, ovf=0.
